// File: rtl/spi_transaction_pkg.sv
// Shared types, defaults and helpers for the SPI register transaction path.
package spi_transaction_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    READ_WAIT = 2'd2
  } transaction_state_t;

  localparam int         NUM_SUBPERIPHERALS_DEFAULT = 4;
  localparam logic [7:0] ADDRESS_BASE_DEFAULT       = 8'hD0;
  localparam int         TIMEOUT_CYCLES_DEFAULT     = 16;
  localparam logic [7:0] FILL_BYTE_DEFAULT          = 8'hFF;

  // Slot assignments of the register subperipherals that exist today.
  localparam int CHIP_ID        = 0;
  localparam int VERSION_STRING = 1;

  function automatic logic [7:0] saturating_increment(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_address_decoder.sv
// Maps a transaction address onto a one-hot slot select plus a mapped flag.
module spi_address_decoder
  import spi_transaction_pkg::*;
#(
  parameter int         NUM_SUBPERIPHERALS = NUM_SUBPERIPHERALS_DEFAULT,
  parameter logic [7:0] ADDRESS_BASE       = ADDRESS_BASE_DEFAULT
) (
  input  logic [7:0]                    address,
  output logic [NUM_SUBPERIPHERALS-1:0] slot_select,
  output logic                          mapped
);

  logic [7:0] offset;

  // Slot k answers ADDRESS_BASE+k; addresses below the base or past the last slot are unmapped.
  always_comb begin
    offset      = address - ADDRESS_BASE;
    mapped      = (address >= ADDRESS_BASE) && (int'(offset) < NUM_SUBPERIPHERALS);
    slot_select = '0;
    for (int k = 0; k < NUM_SUBPERIPHERALS; k++) begin
      if (mapped && (int'(offset) == k)) begin
        slot_select[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_transaction_controller.sv
// Routes SPI transactions to one register subperipheral: decode, byte strobes, read wait and timeout.
module spi_transaction_controller
  import spi_transaction_pkg::*;
#(
  parameter int         NUM_SUBPERIPHERALS = NUM_SUBPERIPHERALS_DEFAULT,
  parameter logic [7:0] ADDRESS_BASE       = ADDRESS_BASE_DEFAULT,
  parameter int         TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0] DEFAULT_BYTE       = FILL_BYTE_DEFAULT
) (
  input  logic                            system_clock,
  input  logic                            system_reset_n,
  input  logic [7:0]                      address_in,
  input  logic                            address_in_valid,
  input  logic [7:0]                      data_in,
  input  logic                            data_in_valid,
  input  logic                            data_request_in,
  output logic [7:0]                      data_out,
  output logic                            data_out_valid,
  output logic [NUM_SUBPERIPHERALS-1:0]   subperipheral_enable_out,
  output logic [7:0]                      subperipheral_data_out,
  output logic [7:0]                      subperipheral_byte_index_out,
  output logic [NUM_SUBPERIPHERALS-1:0]   subperipheral_write_strobe_out,
  output logic [NUM_SUBPERIPHERALS-1:0]   subperipheral_read_strobe_out,
  input  logic [NUM_SUBPERIPHERALS*8-1:0] subperipheral_data_in,
  input  logic [NUM_SUBPERIPHERALS-1:0]   subperipheral_data_in_valid,
  output logic [7:0]                      timeout_count_out
);

  localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

  transaction_state_t state, state_next;

  logic                          address_valid_q;
  logic                          address_rise;
  logic                          address_fall;
  logic [NUM_SUBPERIPHERALS-1:0] decoded_select;
  logic                          decoded_mapped;
  logic                          transaction_mapped;
  logic [7:0]                    byte_index;
  logic [TIMER_WIDTH-1:0]        read_timer;
  logic                          accept_write;
  logic                          accept_read;
  logic                          response_hit;
  logic                          response_timeout;
  logic [7:0]                    response_byte;

  spi_address_decoder #(
    .NUM_SUBPERIPHERALS (NUM_SUBPERIPHERALS),
    .ADDRESS_BASE       (ADDRESS_BASE)
  ) address_decoder (
    .address     (address_in),
    .slot_select (decoded_select),
    .mapped      (decoded_mapped)
  );

  // Qualify byte, request and response events; a closing transaction suppresses everything else.
  always_comb begin
    address_rise  = address_in_valid && !address_valid_q;
    address_fall  = !address_in_valid && address_valid_q;
    response_byte = '0;
    for (int k = 0; k < NUM_SUBPERIPHERALS; k++) begin
      if (subperipheral_enable_out[k]) begin
        response_byte = response_byte | subperipheral_data_in[8*k +: 8];
      end
    end
    accept_write     = (state != IDLE) && data_in_valid && !address_fall;
    accept_read      = (state == ACTIVE) && data_request_in && !address_fall;
    response_hit     = (state == READ_WAIT) && !address_fall
                       && (|(subperipheral_data_in_valid & subperipheral_enable_out));
    response_timeout = (state == READ_WAIT) && !address_fall && !response_hit
                       && (read_timer == TIMER_LIMIT);
    state_next = state;
    unique case (state)
      IDLE: begin
        if (address_rise) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (address_fall) state_next = IDLE;
        else if (accept_read && transaction_mapped) state_next = READ_WAIT;
      end
      READ_WAIT: begin
        if (address_fall) state_next = IDLE;
        else if (response_hit || response_timeout) state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) state <= IDLE;
    else                 state <= state_next;
  end

  // Datapath: decode latch, byte index, strobes, read timer, returned byte and timeout counter.
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      address_valid_q                <= 1'b0;
      transaction_mapped             <= 1'b0;
      byte_index                     <= '0;
      read_timer                     <= '0;
      subperipheral_enable_out       <= '0;
      subperipheral_data_out         <= '0;
      subperipheral_byte_index_out   <= '0;
      subperipheral_write_strobe_out <= '0;
      subperipheral_read_strobe_out  <= '0;
      data_out                       <= '0;
      data_out_valid                 <= 1'b0;
      timeout_count_out              <= '0;
    end else begin
      address_valid_q                <= address_in_valid;
      subperipheral_write_strobe_out <= '0;
      subperipheral_read_strobe_out  <= '0;
      if (state == IDLE) begin
        if (address_rise) begin
          subperipheral_enable_out <= decoded_select;
          transaction_mapped       <= decoded_mapped;
          byte_index               <= '0;
        end
      end else if (address_fall) begin
        subperipheral_enable_out <= '0;
        transaction_mapped       <= 1'b0;
        byte_index               <= '0;
        data_out_valid           <= 1'b0;
      end else begin
        if (accept_write) begin
          if (transaction_mapped) begin
            subperipheral_write_strobe_out <= subperipheral_enable_out;
            subperipheral_data_out         <= data_in;
            subperipheral_byte_index_out   <= byte_index;
          end
          byte_index <= byte_index + 8'd1;
        end
        if (accept_read) begin
          if (transaction_mapped) begin
            subperipheral_read_strobe_out <= subperipheral_enable_out;
            subperipheral_byte_index_out  <= byte_index;
            data_out_valid                <= 1'b0;
            read_timer                    <= '0;
          end else begin
            data_out       <= DEFAULT_BYTE;
            data_out_valid <= 1'b1;
          end
        end
        if (state == READ_WAIT) begin
          if (response_hit) begin
            data_out       <= response_byte;
            data_out_valid <= 1'b1;
          end else if (response_timeout) begin
            data_out          <= DEFAULT_BYTE;
            data_out_valid    <= 1'b1;
            timeout_count_out <= saturating_increment(timeout_count_out);
          end else begin
            read_timer <= read_timer + TIMER_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Scoreboard bench for spi_transaction_controller: directed scenarios followed by randomized transactions.
module tb_spi_transaction_controller;
  import spi_transaction_pkg::*;

  localparam int         NUM_SLOTS = 4;
  localparam int         TIMEOUT   = 16;
  localparam logic [7:0] BASE      = 8'hD0;
  localparam logic [7:0] FILL      = 8'hFF;
  localparam int         SILENT    = -1;

  logic                   system_clock = 1'b0;
  logic                   system_reset_n;
  logic [7:0]             address_in;
  logic                   address_in_valid;
  logic [7:0]             data_in;
  logic                   data_in_valid;
  logic                   data_request_in;
  logic [7:0]             data_out;
  logic                   data_out_valid;
  logic [NUM_SLOTS-1:0]   enable;
  logic [7:0]             sub_data_out;
  logic [7:0]             sub_index_out;
  logic [NUM_SLOTS-1:0]   write_strobe;
  logic [NUM_SLOTS-1:0]   read_strobe;
  logic [NUM_SLOTS*8-1:0] subperipheral_data_in;
  logic [NUM_SLOTS-1:0]   subperipheral_data_in_valid;
  logic [7:0]             timeout_count_out;

  spi_transaction_controller #(
    .NUM_SUBPERIPHERALS (NUM_SLOTS),
    .ADDRESS_BASE       (BASE),
    .TIMEOUT_CYCLES     (TIMEOUT),
    .DEFAULT_BYTE       (FILL)
  ) dut (
    .system_clock                   (system_clock),
    .system_reset_n                 (system_reset_n),
    .address_in                     (address_in),
    .address_in_valid               (address_in_valid),
    .data_in                        (data_in),
    .data_in_valid                  (data_in_valid),
    .data_request_in                (data_request_in),
    .data_out                       (data_out),
    .data_out_valid                 (data_out_valid),
    .subperipheral_enable_out       (enable),
    .subperipheral_data_out         (sub_data_out),
    .subperipheral_byte_index_out   (sub_index_out),
    .subperipheral_write_strobe_out (write_strobe),
    .subperipheral_read_strobe_out  (read_strobe),
    .subperipheral_data_in          (subperipheral_data_in),
    .subperipheral_data_in_valid    (subperipheral_data_in_valid),
    .timeout_count_out              (timeout_count_out)
  );

  typedef struct { int cyc; int slot; logic [7:0] idx; logic [7:0] data; } write_exp_t;
  typedef struct { int cyc; int slot; logic [7:0] idx; } read_exp_t;
  typedef struct { int cyc; logic [7:0] data; } data_exp_t;

  write_exp_t write_q[$];
  read_exp_t  read_q[$];
  data_exp_t  data_q[$];

  int   tests    = 0;
  int   failures = 0;
  int   cycle    = 0;
  logic prev_valid = 1'b0;

  // Reference model of the open transaction.
  bit         cur_mapped;
  int         cur_slot;
  logic [7:0] cur_index;
  logic [7:0] exp_timeouts;
  logic [7:0] last_data;
  bit         unmapped_read_used;

  // 50 MHz system clock.
  always #10 system_clock = ~system_clock;

  // Cycle counter used to time-stamp every expected event.
  always @(posedge system_clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: compare every strobe and every newly presented data byte against the scoreboard.
  always @(negedge system_clock) begin
    if (|write_strobe) begin
      if (write_q.size() == 0) checkOutput("unexpected_write", 64'(write_strobe), 64'd0);
      else begin
        checkOutput("write_strobe",
                    {32'(cycle), 8'(write_strobe), sub_index_out, sub_data_out, 8'h00},
                    {32'(write_q[0].cyc), 8'(1 << write_q[0].slot), write_q[0].idx, write_q[0].data, 8'h00});
        void'(write_q.pop_front());
      end
    end
    if (|read_strobe) begin
      if (read_q.size() == 0) checkOutput("unexpected_read", 64'(read_strobe), 64'd0);
      else begin
        checkOutput("read_strobe",
                    {32'(cycle), 8'(read_strobe), sub_index_out, 7'd0, data_out_valid, 8'h00},
                    {32'(read_q[0].cyc), 8'(1 << read_q[0].slot), read_q[0].idx, 8'h00, 8'h00});
        void'(read_q.pop_front());
      end
    end
    if (data_out_valid && !prev_valid) begin
      if (data_q.size() == 0) checkOutput("unexpected_data", 64'(data_out), 64'hDEAD);
      else begin
        checkOutput("data_out", {32'(cycle), 24'd0, data_out}, {32'(data_q[0].cyc), 24'd0, data_q[0].data});
        void'(data_q.pop_front());
      end
    end
    prev_valid <= data_out_valid;
  end

  // Hard bound on simulated time.
  initial begin
    #(20 * 100000);
    $display("[TB] FAIL watchdog: simulation did not complete within 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  function automatic bit is_mapped(input logic [7:0] addr);
    return (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + NUM_SLOTS);
  endfunction

  task automatic check_reset_outputs();
    checkOutput("reset_data_out", 64'(data_out), 64'd0);
    checkOutput("reset_data_out_valid", 64'(data_out_valid), 64'd0);
    checkOutput("reset_enable", 64'(enable), 64'd0);
    checkOutput("reset_strobes", {56'd0, write_strobe, read_strobe}, 64'd0);
    checkOutput("reset_bus", {48'd0, sub_data_out, sub_index_out}, 64'd0);
    checkOutput("reset_timeout_count", 64'(timeout_count_out), 64'd0);
  endtask

  task automatic start_transaction(input logic [7:0] addr);
    address_in         = addr;
    address_in_valid   = 1'b1;
    cur_mapped         = is_mapped(addr);
    cur_slot           = int'(addr) - int'(BASE);
    cur_index          = 8'd0;
    unmapped_read_used = 1'b0;
    tick();
    checkOutput("enable_on_start", 64'(enable), cur_mapped ? 64'(1 << cur_slot) : 64'd0);
  endtask

  task automatic end_transaction();
    address_in_valid = 1'b0;
    tick();
    checkOutput("enable_after_end", 64'(enable), 64'd0);
    checkOutput("valid_after_end", 64'(data_out_valid), 64'd0);
    checkOutput("data_held_after_end", 64'(data_out), 64'(last_data));
    tick();
  endtask

  // One byte slot: optional write, optional read, plus the slot's response after 'delay' cycles.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] wdata, input int delay,
                               input logic [7:0] rdata, input bit extra_req, input bit noise);
    int         t;
    int         kmax;
    bit         answers;
    write_exp_t w;
    read_exp_t  r;
    data_exp_t  d;
    t       = cycle;
    answers = (delay >= 1) && (delay <= TIMEOUT);
    data_in         = wdata;
    data_in_valid   = wr;
    data_request_in = rd;
    if (wr && cur_mapped) begin
      w.cyc = t + 1; w.slot = cur_slot; w.idx = cur_index; w.data = wdata;
      write_q.push_back(w);
    end
    if (rd) begin
      if (cur_mapped) begin
        r.cyc = t + 1; r.slot = cur_slot; r.idx = cur_index;
        read_q.push_back(r);
        if (answers) begin
          d.cyc = t + 2 + delay; d.data = rdata;
        end else begin
          d.cyc = t + 2 + TIMEOUT; d.data = FILL;
          if (exp_timeouts != 8'd255) exp_timeouts++;
        end
      end else begin
        d.cyc = t + 1; d.data = FILL;
      end
      data_q.push_back(d);
      last_data = d.data;
    end
    if (wr) cur_index++;
    tick();
    data_in_valid   = 1'b0;
    data_request_in = 1'b0;
    if (rd && cur_mapped) begin
      kmax = answers ? delay + 1 : TIMEOUT + 1;
      for (int k = 0; k < kmax; k++) begin
        subperipheral_data_in       = $urandom();
        subperipheral_data_in_valid = '0;
        if (k == delay) begin
          subperipheral_data_in[8*cur_slot +: 8] = rdata;
          subperipheral_data_in_valid[cur_slot]  = 1'b1;
        end
        if (noise && k == 0) subperipheral_data_in_valid[(cur_slot + 1) % NUM_SLOTS] = 1'b1;
        if (extra_req && k == 1) data_request_in = 1'b1;
        tick();
        data_request_in             = 1'b0;
        subperipheral_data_in_valid = '0;
      end
    end
  endtask

  task automatic abort_during_read(input logic [7:0] addr, input int wait_cycles);
    read_exp_t r;
    start_transaction(addr);
    r.cyc = cycle + 1; r.slot = cur_slot; r.idx = cur_index;
    read_q.push_back(r);
    data_request_in = 1'b1;
    tick();
    data_request_in = 1'b0;
    repeat (wait_cycles) tick();
    address_in_valid = 1'b0;
    tick();
    checkOutput("abort_valid_cleared", 64'(data_out_valid), 64'd0);
    checkOutput("abort_enable_cleared", 64'(enable), 64'd0);
    checkOutput("abort_data_held", 64'(data_out), 64'(last_data));
    repeat (TIMEOUT + 2) tick();
    checkOutput("abort_no_timeout", 64'(timeout_count_out), 64'(exp_timeouts));
  endtask

  task automatic reset_during_read();
    read_exp_t r;
    start_transaction(8'hD1);
    r.cyc = cycle + 1; r.slot = cur_slot; r.idx = cur_index;
    read_q.push_back(r);
    data_request_in = 1'b1;
    tick();
    data_request_in = 1'b0;
    repeat (3) tick();
    system_reset_n   = 1'b0;
    address_in_valid = 1'b0;
    tick();
    exp_timeouts = 8'd0;
    last_data    = 8'd0;
    check_reset_outputs();
    system_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] addr;
    int         kind;
    int         delay;
    bit         wr;
    bit         rd;
    system_reset_n              = 1'b0;
    address_in                  = 8'd0;
    address_in_valid            = 1'b0;
    data_in                     = 8'd0;
    data_in_valid               = 1'b0;
    data_request_in             = 1'b0;
    subperipheral_data_in       = '0;
    subperipheral_data_in_valid = '0;
    exp_timeouts                = 8'd0;
    last_data                   = 8'd0;
    repeat (3) tick();
    check_reset_outputs();
    system_reset_n = 1'b1;
    tick();

    // Chip id read answered two cycles after the strobe.
    start_transaction(BASE + 8'(CHIP_ID));
    applyStimulus(1'b0, 1'b1, 8'h00, 2, 8'h81, 1'b0, 1'b0);
    checkOutput("chip_id_timeouts", 64'(timeout_count_out), 64'(exp_timeouts));
    end_transaction();

    // Three-byte write, then a long write burst that wraps the byte index.
    start_transaction(8'hD1);
    applyStimulus(1'b1, 1'b0, 8'hAA, SILENT, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hBB, SILENT, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hCC, SILENT, 8'h00, 1'b0, 1'b0);
    end_transaction();
    start_transaction(BASE + 8'(VERSION_STRING));
    repeat (258) applyStimulus(1'b1, 1'b0, 8'($urandom), SILENT, 8'h00, 1'b0, 1'b0);
    end_transaction();

    // Timeout, then saturation of the timeout counter.
    start_transaction(8'hD2);
    applyStimulus(1'b0, 1'b1, 8'h00, SILENT, 8'h00, 1'b0, 1'b0);
    checkOutput("first_timeout", 64'(timeout_count_out), 64'd1);
    repeat (259) applyStimulus(1'b0, 1'b1, 8'h00, SILENT, 8'h00, 1'b0, 1'b0);
    checkOutput("timeout_saturated", 64'(timeout_count_out), 64'd255);
    end_transaction();

    // Reset in the middle of a pending read.
    reset_during_read();

    // Unmapped addresses, including both neighbours of the mapped window.
    start_transaction(8'h10);
    applyStimulus(1'b1, 1'b1, 8'h5A, SILENT, 8'h00, 1'b0, 1'b0);
    checkOutput("unmapped_timeouts", 64'(timeout_count_out), 64'(exp_timeouts));
    end_transaction();
    start_transaction(8'hCF);
    applyStimulus(1'b0, 1'b1, 8'h00, SILENT, 8'h00, 1'b0, 1'b0);
    end_transaction();
    start_transaction(8'hD4);
    applyStimulus(1'b1, 1'b1, 8'h33, SILENT, 8'h00, 1'b0, 1'b0);
    end_transaction();

    // Collisions: write+read at index 5, ignored second request, response on the timeout cycle.
    start_transaction(8'hD3);
    repeat (5) applyStimulus(1'b1, 1'b0, 8'($urandom), SILENT, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h55, 3, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h66, SILENT, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 5, 8'h4D, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h00, TIMEOUT, 8'h5E, 1'b0, 1'b0);
    checkOutput("collision_timeouts", 64'(timeout_count_out), 64'(exp_timeouts));
    end_transaction();

    // Abort while a read is outstanding.
    abort_during_read(8'hD2, 5);
    abort_during_read(8'hD0, TIMEOUT - 2);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do addr = 8'($urandom); while (is_mapped(addr));
      end else begin
        addr = BASE + 8'($urandom_range(0, NUM_SLOTS - 1));
      end
      start_transaction(addr);
      repeat ($urandom_range(2, 10)) begin
        kind = $urandom_range(0, 9);
        wr   = (kind < 6) || (kind == 9);
        rd   = (kind >= 6);
        if (rd && !cur_mapped) begin
          if (unmapped_read_used) rd = 1'b0;
          unmapped_read_used = 1'b1;
        end
        if (!wr && !rd) wr = 1'b1;
        delay = ($urandom_range(0, 3) == 0) ? SILENT : $urandom_range(1, TIMEOUT);
        applyStimulus(wr, rd, 8'($urandom), delay, 8'($urandom),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        checkOutput("random_timeouts", 64'(timeout_count_out), 64'(exp_timeouts));
      end
      end_transaction();
    end

    repeat (4) tick();
    checkOutput("missing_write", 64'(write_q.size()), 64'd0);
    checkOutput("missing_read", 64'(read_q.size()), 64'd0);
    checkOutput("missing_data", 64'(data_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/spi_transaction_controller.md
Name: spi_transaction_controller

Overview:
- Sits between spi_peripheral and the SPI register subperipherals (chip_id, version_string, and later camera and display control registers).
- Latches and decodes the transaction address, then enables exactly one subperipheral.
- Issues per-byte write and read strobes carrying a byte index, and waits for read responses.
- Substitutes a default byte on timeout or unmapped address, and counts timeouts for diagnostics.

Parameters:
NUM_SUBPERIPHERALS, 4, number of subperipheral slots
ADDRESS_BASE, 8'hD0, slot k answers address ADDRESS_BASE+k
TIMEOUT_CYCLES, 16, system_clock cycles allowed for a read response, minimum 2
DEFAULT_BYTE, 8'hFF, byte returned on timeout or unmapped read

Ports:
system_clock  in  1  system clock, 50 MHz
system_reset_n  in  1  synchronous, active-low reset
address_in  in  8  transaction address from spi_peripheral
address_in_valid  in  1  high for the whole transaction after the address byte arrives
data_in  in  8  received COPI byte
data_in_valid  in  1  one-cycle pulse at every SPI byte boundary
data_request_in  in  1  one-cycle pulse when spi_peripheral needs the next CIPO byte
data_out  out  8  CIPO byte to spi_peripheral
data_out_valid  out  1  data_out valid, held until the next request or end of transaction
subperipheral_enable_out  out  N  one-hot enable to the selected slot
subperipheral_data_out  out  8  shared write data
subperipheral_byte_index_out  out  8  byte index for the current strobe
subperipheral_write_strobe_out  out  N  one-cycle write strobe
subperipheral_read_strobe_out  out  N  one-cycle read strobe
subperipheral_data_in  in  N*8  read data, slot k in bits [8k+7:8k]
subperipheral_data_in_valid  in  N  one-cycle read-data pulse per slot
timeout_count_out  out  8  saturating count of read timeouts

Behaviour:

Reset:
- Synchronous, active-low, on system_clock.
- All outputs go to 0 (data_out 0, timeout_count_out 0). State goes to IDLE and byte index to 0.

States:
- IDLE: wait for the address.
- ACTIVE: transaction open.
- READ_WAIT: read strobe issued, waiting for the response.

Transaction start and decode:
- A rising edge of address_in_valid is detected against a registered copy.
- The cycle after the edge: state moves to ACTIVE and address_in is decoded.
  - Mapped address: subperipheral_enable_out = one-hot of (address_in - ADDRESS_BASE).
  - Unmapped address: enable stays 0 and the transaction is flagged unmapped.
- Byte index is set to 0.

Writes (ACTIVE or READ_WAIT):
- data_in_valid at cycle t gives the following at t+1, for one cycle on the selected slot:
  - subperipheral_write_strobe_out asserted;
  - subperipheral_data_out = data_in;
  - subperipheral_byte_index_out = current index.
- The index then increments, wrapping 255 to 0.
- Unmapped transaction: no strobe is issued, but the index still increments.

Reads (from ACTIVE):
- data_request_in at cycle t gives the following at t+1:
  - data_out_valid drops;
  - subperipheral_read_strobe_out pulses with the current index;
  - state moves to READ_WAIT and the timer loads 0.
- In READ_WAIT, when the selected slot's valid pulse arrives, at the next cycle:
  - data_out = that slot's byte;
  - data_out_valid = 1;
  - state returns to ACTIVE.
- If the timer reaches TIMEOUT_CYCLES with no response:
  - data_out = DEFAULT_BYTE and data_out_valid = 1;
  - timeout_count_out increments, saturating at 255;
  - state returns to ACTIVE.
- Unmapped read: data_out = DEFAULT_BYTE with valid at t+1. No strobe is issued and nothing is counted.

Simultaneous and boundary events:
- data_in_valid and data_request_in in the same cycle: both strobes fire at t+1 with the same index, and the index increments once.
- data_request_in during READ_WAIT is ignored: no extra strobe, no queueing.
- Valid pulses from non-selected slots are ignored.
- Response and timeout in the same cycle: the response wins and no timeout is counted.
- Falling edge of address_in_valid in any state gives, at the next cycle:
  - state IDLE;
  - enable, strobes and data_out_valid cleared, index 0;
  - any pending read abandoned without counting a timeout.
  - data_out keeps its last value.
- Reset asserted mid-transaction overrides everything in that cycle.

Decomposition:
- Package spi_transaction_pkg holds:
  - state enum (IDLE, ACTIVE, READ_WAIT);
  - default constants for ADDRESS_BASE, DEFAULT_BYTE, TIMEOUT_CYCLES;
  - subperipheral slot index constants (CHIP_ID=0, VERSION_STRING=1).
- One sub-module: spi_address_decoder, combinational. It maps address to a one-hot N-bit select plus a mapped flag, and is reused by future register banks.

Test Plan:
1. Chip_id read: address 8'hD0, data_request_in, slot 0 answers 8'h81 two cycles after the strobe → enable 4'b0001; read strobe at index 0; data_out 8'h81 with valid one cycle after the response; timeout_count_out 0.
2. Three-byte write: address 8'hD1, data 8'hAA/8'hBB/8'hCC → slot 1 sees three write strobes with indices 0/1/2 and matching data; falling edge of address_in_valid clears enable and resets the index to 0.
3. Timeout: address 8'hD2, request, slot 2 silent → data_out 8'hFF valid exactly TIMEOUT_CYCLES+1 cycles after the strobe; timeout_count_out 1. 260 repeated timeouts → saturates at 255.
4. Unmapped address: address 8'h10, request plus data_in_valid → no enable and no strobes; data_out 8'hFF valid at t+1; timeout_count_out unchanged.
5. Collisions:
   - Simultaneous data_in_valid and data_request_in at index 5 → both strobes at index 5, next index 6.
   - Second request during READ_WAIT → ignored.
   - Response on the same cycle as the timeout → response data returned, no count.
6. Aborts:
   - address_in_valid drops during READ_WAIT → IDLE, data_out_valid 0, no timeout counted.
   - Reset asserted mid-read → all outputs 0 on the next edge.
